// File: rtl/mem_req_arbiter.sv
// Two-master memory request arbiter: grants m0 (instruction) or m1 (data) access to a
// single SRAM-style port, translates kseg0/kseg1 addresses to physical, tags uncached
// accesses, and keeps exactly one transaction in flight (IDLE -> ADDR -> DATA).
module mem_req_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    // Master 0 (instruction side)
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [1:0]        m0_size,
    input  logic [31:0]       m0_addr,
    input  logic [3:0]        m0_wstrb,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_addr_ok,
    output logic              m0_data_ok,
    output logic [DATA_W-1:0] m0_rdata,
    // Master 1 (data side)
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [1:0]        m1_size,
    input  logic [31:0]       m1_addr,
    input  logic [3:0]        m1_wstrb,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_addr_ok,
    output logic              m1_data_ok,
    output logic [DATA_W-1:0] m1_rdata,
    // Downstream port
    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [31:0]       s_addr,
    output logic [3:0]        s_wstrb,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_cached,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,
    input  logic [DATA_W-1:0] s_rdata
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e              state_q, state_d;
    // Doubles as the owner of the in-flight transaction (1 = m1).
    logic                last_grant_q, last_grant_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [31:0]         addr_q, addr_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cached_q, cached_d;

    logic                any_req;
    logic                grant_m1;
    logic                accept;
    logic                complete;
    logic [31:0]         sel_addr;

    // kseg0 (8/9) and kseg1 (A/B) fold onto physical segments 0/1.
    function automatic logic [31:0] kseg_xlate(input logic [31:0] va);
        logic [31:0] pa;
        pa = va;
        case (va[31:28])
            4'h8, 4'hA: pa[31:28] = 4'h0;
            4'h9, 4'hB: pa[31:28] = 4'h1;
            default:    pa[31:28] = va[31:28];
        endcase
        return pa;
    endfunction

    // Arbitration and transaction-boundary decode
    always_comb begin
        any_req  = m0_req | m1_req;
        // With both requesting, round-robin favours the master that did not win last.
        grant_m1 = m1_req & (~m0_req | FIXED_PRIO | ~last_grant_q);
        accept   = (state_q == StIdle) & any_req;
        complete = ((state_q == StAddr) & s_addr_ok & s_data_ok) |
                   ((state_q == StData) & s_data_ok);
    end

    // Next-state and request latching
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        cached_d     = cached_q;
        sel_addr     = grant_m1 ? m1_addr : m0_addr;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d      = StAddr;
                    last_grant_d = grant_m1;
                    wr_d         = grant_m1 ? m1_wr    : m0_wr;
                    size_d       = grant_m1 ? m1_size  : m0_size;
                    wstrb_d      = grant_m1 ? m1_wstrb : m0_wstrb;
                    wdata_d      = grant_m1 ? m1_wdata : m0_wdata;
                    addr_d       = kseg_xlate(sel_addr);
                    cached_d     = ~((sel_addr[31:28] == 4'hA) | (sel_addr[31:28] == 4'hB));
                end
            end
            StAddr: begin
                if (s_addr_ok) begin
                    state_d = s_data_ok ? StIdle : StData;
                end
            end
            StData: begin
                if (s_data_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'd0;
            wstrb_q      <= 4'd0;
            wdata_q      <= '0;
            cached_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            cached_q     <= cached_d;
        end
    end

    // Handshake pulses and downstream fields
    always_comb begin
        m0_addr_ok = accept & ~grant_m1;
        m1_addr_ok = accept & grant_m1;
        m0_data_ok = complete & ~last_grant_q;
        m1_data_ok = complete & last_grant_q;
        m0_rdata   = s_rdata;
        m1_rdata   = s_rdata;
        s_req      = (state_q == StAddr);
        s_wr       = wr_q;
        s_size     = size_q;
        s_addr     = addr_q;
        s_wstrb    = wstrb_q;
        s_wdata    = wdata_q;
        s_cached   = cached_q;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: a stimulus process issues requests and queues the
// expected grant/translation; a monitor checks every addr_ok, bus cycle and data_ok.
`timescale 1ns/1ps
module tb_mem_req_arbiter;

    typedef struct packed {
        logic        m;
        logic [31:0] addr;
        logic        cached;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        resetn;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr, s_cached, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;

    // Fixed-priority instance
    logic        f_req0, f_req1, f_sack;
    logic        f_a0, f_a1, f_d0, f_d1, f_sreq, f_swr, f_scached;
    logic [1:0]  f_ssize;
    logic [31:0] f_saddr, f_swdata, f_rd0, f_rd1;
    logic [3:0]  f_swstrb;

    int   checks = 0;
    int   errors = 0;
    txn_t grant_q[$];
    logic done_q[$];
    txn_t cur;
    bit   cur_v = 0;
    bit   m_last = 1'b1;
    bit   resp_en = 1'b1;
    int   phase = 0;

    mem_req_arbiter #(.DATA_W(32), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wstrb(s_wstrb),
        .s_wdata(s_wdata), .s_cached(s_cached), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    mem_req_arbiter #(.DATA_W(32), .FIXED_PRIO(1'b1)) dut_fix (
        .clk(clk), .resetn(resetn),
        .m0_req(f_req0), .m0_wr(1'b0), .m0_size(2'd2), .m0_addr(32'hBFC0_0100),
        .m0_wstrb(4'hF), .m0_wdata(32'h0), .m0_addr_ok(f_a0), .m0_data_ok(f_d0),
        .m0_rdata(f_rd0),
        .m1_req(f_req1), .m1_wr(1'b1), .m1_size(2'd2), .m1_addr(32'h8000_0200),
        .m1_wstrb(4'hF), .m1_wdata(32'h1234_5678), .m1_addr_ok(f_a1), .m1_data_ok(f_d1),
        .m1_rdata(f_rd1),
        .s_req(f_sreq), .s_wr(f_swr), .s_size(f_ssize), .s_addr(f_saddr), .s_wstrb(f_swstrb),
        .s_wdata(f_swdata), .s_cached(f_scached), .s_addr_ok(f_sack), .s_data_ok(f_sack),
        .s_rdata(32'hDEAD_BEEF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: kseg0/kseg1 windows (0x8000_0000..0xBFFF_FFFF) drop the top three bits.
    function automatic txn_t model_txn(input logic m, input logic [31:0] va, input logic wr,
                                       input logic [1:0] size, input logic [3:0] wstrb,
                                       input logic [31:0] wdata);
        txn_t t;
        t.m      = m;
        t.addr   = (va >= 32'h8000_0000 && va < 32'hC000_0000) ? (va & 32'h1FFF_FFFF) : va;
        t.cached = !(va >= 32'hA000_0000 && va < 32'hC000_0000);
        t.wr     = wr;
        t.size   = size;
        t.wstrb  = wstrb;
        t.wdata  = wdata;
        return t;
    endfunction

    task automatic do_txn(input bit r0, input bit r1, input logic [31:0] a0,
                          input logic [31:0] a1);
        bit win;
        int n;
        @(posedge clk); #1;
        m0_wr = 1'($urandom_range(0, 1)); m0_size = 2'($urandom_range(0, 2));
        m0_wstrb = 4'($urandom); m0_wdata = $urandom; m0_addr = a0; m0_req = r0;
        m1_wr = 1'($urandom_range(0, 1)); m1_size = 2'($urandom_range(0, 2));
        m1_wstrb = 4'($urandom); m1_wdata = $urandom; m1_addr = a1; m1_req = r1;
        win = (r0 && r1) ? !m_last : r1;
        m_last = win;
        if (win) grant_q.push_back(model_txn(1'b1, a1, m1_wr, m1_size, m1_wstrb, m1_wdata));
        else     grant_q.push_back(model_txn(1'b0, a0, m0_wr, m0_size, m0_wstrb, m0_wdata));
        n = 0;
        @(negedge clk);
        while (!(m0_addr_ok || m1_addr_ok) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            chk(1'b0, "addr_ok_timeout", 0, 1);
            grant_q.delete();
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(m0_data_ok || m1_data_ok) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            chk(1'b0, "data_ok_timeout", 0, 1);
            done_q.delete();
            cur_v = 0;
        end
    endtask

    // Downstream responder: random address/data latency, plus stray strobes when idle
    initial begin
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (resp_en) begin
                s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = $urandom;
                if (phase == 0) begin
                    if (s_req) begin
                        if ($urandom_range(0, 2) == 0) begin
                            s_addr_ok = 1'b1;
                            if ($urandom_range(0, 2) == 0) s_data_ok = 1'b1;
                            else phase = 1;
                        end
                    end else begin
                        if ($urandom_range(0, 7) == 0) s_data_ok = 1'b1;
                        if ($urandom_range(0, 7) == 0) s_addr_ok = 1'b1;
                    end
                end else begin
                    if ($urandom_range(0, 1) == 0) begin
                        s_data_ok = 1'b1;
                        phase = 0;
                    end
                    if ($urandom_range(0, 5) == 0) s_addr_ok = 1'b1;
                end
            end
        end
    end

    // Monitor: compare every DUT handshake against the scoreboard queues
    always @(negedge clk) begin
        if (resetn) begin
            if (m0_addr_ok || m1_addr_ok) begin
                if (grant_q.size() == 0) begin
                    chk(1'b0, "addr_ok_unexpected", {m1_addr_ok, m0_addr_ok}, 0);
                end else begin
                    cur = grant_q.pop_front();
                    cur_v = 1;
                    chk({m1_addr_ok, m0_addr_ok} == (cur.m ? 2'b10 : 2'b01), "grant",
                        {m1_addr_ok, m0_addr_ok}, cur.m ? 2'b10 : 2'b01);
                end
            end
            if (s_req) begin
                if (!cur_v) begin
                    chk(1'b0, "s_req_unexpected", 1, 0);
                end else begin
                    chk({s_addr, s_cached, s_wr, s_size, s_wstrb, s_wdata} ==
                        {cur.addr, cur.cached, cur.wr, cur.size, cur.wstrb, cur.wdata},
                        "s_fields", {s_addr, s_cached, s_wr, s_size, s_wstrb, s_wdata},
                        {cur.addr, cur.cached, cur.wr, cur.size, cur.wstrb, cur.wdata});
                    if (s_addr_ok) begin
                        done_q.push_back(cur.m);
                        cur_v = 0;
                    end
                end
            end
            if (m0_data_ok || m1_data_ok) begin
                if (done_q.size() == 0) begin
                    chk(1'b0, "data_ok_unexpected", {m1_data_ok, m0_data_ok}, 0);
                end else begin
                    logic own;
                    own = done_q.pop_front();
                    chk({m1_data_ok, m0_data_ok} == (own ? 2'b10 : 2'b01), "data_ok_owner",
                        {m1_data_ok, m0_data_ok}, own ? 2'b10 : 2'b01);
                    chk(m0_rdata == s_rdata && m1_rdata == s_rdata, "rdata",
                        {m0_rdata, m1_rdata}, {s_rdata, s_rdata});
                end
            end
        end
    end

    // Stimulus
    initial begin
        int cnt0, cnt1, cntd;
        logic [1:0] pat;
        resetn = 1'b0;
        m0_req = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_wstrb = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_wstrb = 0; m1_wdata = 0;
        f_req0 = 0; f_req1 = 0; f_sack = 0;
        repeat (2) @(negedge clk);
        chk(s_req == 0 && {m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok} == 0, "reset_ctl",
            {s_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, 0);
        chk({s_addr, s_cached, s_wr, s_size, s_wstrb, s_wdata} == 0, "reset_fields",
            {s_addr, s_cached, s_wr, s_size, s_wstrb, s_wdata}, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Directed: translation cases, then round-robin with both requesting
        do_txn(1'b1, 1'b0, 32'hBFC0_0000, 32'h0);
        do_txn(1'b0, 1'b1, 32'h0, 32'h8000_1234);
        repeat (4) do_txn(1'b1, 1'b1, 32'h9000_0010, 32'hA000_0020);
        do_txn(1'b1, 1'b0, 32'h4000_0000, 32'h0);

        // Reset while in DATA: transaction dropped, no data_ok
        resp_en = 1'b0;
        @(posedge clk); #1;
        s_addr_ok = 1'b0; s_data_ok = 1'b0;
        m0_addr = 32'h9000_0040; m0_wr = 1'b0; m0_size = 2'd2; m0_wstrb = 4'hF;
        m0_wdata = 32'h0; m0_req = 1'b1;
        grant_q.push_back(model_txn(1'b0, m0_addr, 1'b0, 2'd2, 4'hF, 32'h0));
        m_last = 1'b0;
        @(posedge clk); #1;
        m0_req = 1'b0; s_addr_ok = 1'b1;
        @(posedge clk); #1;
        s_addr_ok = 1'b0;
        #2 resetn = 1'b0;
        #1;
        s_data_ok = 1'b1;
        #1;
        chk(s_req == 0 && m0_data_ok == 0 && m1_data_ok == 0, "reset_mid_txn",
            {s_req, m0_data_ok, m1_data_ok}, 0);
        done_q.delete(); grant_q.delete(); cur_v = 0; m_last = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk(m0_data_ok == 0 && m1_data_ok == 0 && s_req == 0, "stray_data_ok_idle",
                {s_req, m0_data_ok, m1_data_ok}, 0);
        end
        @(posedge clk); #1;
        s_data_ok = 1'b0; phase = 0; resp_en = 1'b1;

        // Fixed priority: m1 wins every time with both requesting
        f_req0 = 1'b1; f_req1 = 1'b1; f_sack = 1'b1;
        cnt0 = 0; cnt1 = 0; cntd = 0;
        repeat (8) begin
            @(negedge clk);
            cnt0 += int'(f_a0);
            cnt1 += int'(f_a1);
            cntd += int'(f_d1);
        end
        @(posedge clk); #1;
        f_req0 = 1'b0; f_req1 = 1'b0; f_sack = 1'b0;
        chk(cnt0 == 0, "fixed_m0_grants", cnt0, 0);
        chk(cnt1 == 4, "fixed_m1_grants", cnt1, 4);
        chk(cntd == 4, "fixed_m1_data_ok", cntd, 4);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            pat = 2'($urandom_range(1, 3));
            do_txn(pat[0], pat[1], {4'($urandom_range(0, 15)), 28'($urandom)},
                   {4'($urandom_range(0, 15)), 28'($urandom)});
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        chk(grant_q.size() == 0 && done_q.size() == 0, "queues_drained",
            {grant_q.size(), done_q.size()}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
